// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command sequencer and its ALU.
package calc_pkg;

  localparam int NREGS_C = 10;
  localparam int DW_C    = 8;
  localparam int AW_C    = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_CLR  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  function automatic logic is_binary(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU used in the EXEC step: result, carry/borrow and zero flag.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DW = DW_C
) (
  input  op_e           i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_imm,
  output logic [DW-1:0] o_r,
  output logic          o_c,
  output logic          o_z
);

  logic [DW:0] w_full;

  // Bit DW carries the ADD carry-out or, for SUB, the borrow (set iff a < b).
  always_comb begin
    w_full = '0;
    case (i_op)
      OP_ADD:  w_full = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  w_full = {1'b0, i_a} - {1'b0, i_b};
      OP_AND:  w_full = {1'b0, i_a & i_b};
      OP_OR:   w_full = {1'b0, i_a | i_b};
      OP_XOR:  w_full = {1'b0, i_a ^ i_b};
      OP_MOV:  w_full = {1'b0, i_a};
      OP_LDI:  w_full = {1'b0, i_imm};
      default: w_full = '0;
    endcase
  end

  assign o_r = w_full[DW-1:0];
  assign o_c = w_full[DW];
  assign o_z = (w_full[DW-1:0] == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Command sequencer driving the single port of the calculator register bank.
//
// state   | meaning
// IDLE    | ready for a command; address check at accept
// RD_A    | rb_address = src_a, capture operand A
// RD_B    | rb_address = src_b, capture operand B
// EXEC    | ALU result and flags registered
// WB      | single write of result to dst
// CLR     | zero registers 0..NREGS-1, one per cycle
// DONE    | one-cycle done pulse, err valid
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int NREGS = NREGS_C,
  parameter int DW    = DW_C,
  parameter int AW    = AW_C
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_src_a,
  input  logic [AW-1:0] cmd_src_b,
  input  logic [AW-1:0] cmd_dst,
  input  logic [DW-1:0] cmd_imm,
  output logic          rb_we,
  output logic [AW-1:0] rb_address,
  output logic [DW-1:0] rb_wdata,
  input  logic [DW-1:0] rb_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] result,
  output logic          flag_c,
  output logic          flag_z
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  state_e        r_state;
  op_e           r_op;
  logic [AW-1:0] r_src_a;
  logic [AW-1:0] r_src_b;
  logic [AW-1:0] r_dst;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_res;
  logic          r_c;
  logic          r_z;
  logic          r_err;
  logic [AW-1:0] r_cnt;

  op_e           w_op;
  logic          w_a_bad;
  logic          w_b_bad;
  logic          w_d_bad;
  logic          w_bad;
  logic [DW-1:0] w_alu_r;
  logic          w_alu_c;
  logic          w_alu_z;

  assign w_op    = op_e'(cmd_op);
  assign w_a_bad = (cmd_src_a > LAST_ADDR);
  assign w_b_bad = (cmd_src_b > LAST_ADDR);
  assign w_d_bad = (cmd_dst > LAST_ADDR);

  // Only the addresses an opcode actually uses are range-checked.
  assign w_bad = (w_d_bad && (w_op != OP_CLR)) ||
                 (w_a_bad && (is_binary(w_op) || (w_op == OP_MOV))) ||
                 (w_b_bad && is_binary(w_op));

  calc_alu #(
    .DW(DW)
  ) u_alu (
    .i_op (r_op),
    .i_a  (r_opa),
    .i_b  (r_opb),
    .i_imm(r_imm),
    .o_r  (w_alu_r),
    .o_c  (w_alu_c),
    .o_z  (w_alu_z)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_imm   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= w_op;
            r_src_a <= cmd_src_a;
            r_src_b <= cmd_src_b;
            r_dst   <= cmd_dst;
            r_imm   <= cmd_imm;
            r_cnt   <= '0;
            r_err   <= w_bad;
            if (w_bad) begin
              r_state <= ST_DONE;
            end else begin
              case (w_op)
                OP_LDI:  r_state <= ST_EXEC;
                OP_CLR:  r_state <= ST_CLR;
                default: r_state <= ST_RD_A;
              endcase
            end
          end
        end
        ST_RD_A: begin
          r_opa   <= rb_rdata;
          r_state <= is_binary(r_op) ? ST_RD_B : ST_EXEC;
        end
        ST_RD_B: begin
          r_opb   <= rb_rdata;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_res   <= w_alu_r;
          r_c     <= w_alu_c;
          r_z     <= w_alu_z;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_state <= ST_DONE;
        end
        ST_CLR: begin
          if (r_cnt == LAST_ADDR) begin
            r_res   <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bank-port outputs decode from state only, so reset drops rb_we at once.
  always_comb begin
    rb_we      = 1'b0;
    rb_address = '0;
    rb_wdata   = '0;
    case (r_state)
      ST_RD_A: rb_address = r_src_a;
      ST_RD_B: rb_address = r_src_b;
      ST_WB: begin
        rb_we      = 1'b1;
        rb_address = r_dst;
        rb_wdata   = r_res;
      end
      ST_CLR: begin
        rb_we      = 1'b1;
        rb_address = r_cnt;
      end
      default: begin
        rb_we      = 1'b0;
        rb_address = '0;
      end
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err && (r_state == ST_DONE);
  assign result    = r_res;
  assign flag_c    = r_c;
  assign flag_z    = r_z;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural register bank.
module tb_calc_sequencer;
  import calc_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic [7:0] imm;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       err;
    int         lat;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_src_a;
  logic [3:0] cmd_src_b;
  logic [3:0] cmd_dst;
  logic [7:0] cmd_imm;
  logic       rb_we;
  logic [3:0] rb_address;
  logic [7:0] rb_wdata;
  logic [7:0] rb_rdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] result;
  logic       flag_c;
  logic       flag_z;

  logic [7:0] bank [10] = '{default: 8'h00};
  wr_t        wlog [$];
  vec_t       sb   [$];
  vec_t       tbl  [16];
  int         cyc_g = 0;
  int         total = 0;
  int         bad   = 0;

  calc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src_a (cmd_src_a),
    .cmd_src_b (cmd_src_b),
    .cmd_dst   (cmd_dst),
    .cmd_imm   (cmd_imm),
    .rb_we     (rb_we),
    .rb_address(rb_address),
    .rb_wdata  (rb_wdata),
    .rb_rdata  (rb_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rb_rdata = (rb_address < 4'd10) ? bank[rb_address] : 8'h00;

  always @(posedge clk) begin
    cyc_g = cyc_g + 1;
    if (reset && rb_we) begin
      wlog.push_back('{cyc_g, rb_address, rb_wdata});
      if (rb_address < 4'd10) bank[rb_address] <= rb_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] d, input logic [7:0] imm, input logic [7:0] res,
                              input logic c, input logic z, input logic e, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.d = d; v.imm = imm;
    v.res = res; v.c = c; v.z = z; v.err = e; v.lat = lat;
    return v;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_cmd(input vec_t v);
    int   n;
    bit   got;
    vec_t e;
    wait_ready();
    wlog.delete();
    cmd_op    = v.op;
    cmd_src_a = v.a;
    cmd_src_b = v.b;
    cmd_dst   = v.d;
    cmd_imm   = v.imm;
    cmd_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n   = 0;
    got = 0;
    while (n < 30 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
    end
    e = sb.pop_front();
    if (!got) begin
      chk("done_timeout", done, 1);
      return;
    end
    chk("latency", n, e.lat);
    chk("err", err, e.err);
    chk("result", result, e.res);
    chk("flag_c", flag_c, e.c);
    chk("flag_z", flag_z, e.z);
    if (e.err) begin
      chk("err_no_write", wlog.size(), 0);
    end else if (e.op == OP_CLR) begin
      chk("clr_writes", wlog.size(), 10);
      for (int i = 0; i < wlog.size() && i < 10; i++) begin
        chk("clr_addr", wlog[i].a, i);
        chk("clr_data", wlog[i].d, 0);
        chk("clr_consecutive", wlog[i].cyc - wlog[0].cyc, i);
      end
      for (int i = 0; i < 10; i++) chk("clr_readback", bank[i], 0);
    end else begin
      chk("wb_count", wlog.size(), 1);
      if (wlog.size() > 0) begin
        chk("wb_addr", wlog[0].a, e.d);
        chk("wb_data", wlog[0].d, e.res);
      end
      chk("bank_dst", bank[e.d], e.res);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_src_a = 4'd0;
    cmd_src_b = 4'd0;
    cmd_dst   = 4'd0;
    cmd_imm   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rb_we", rb_we, 0);
    chk("rst_rb_address", rb_address, 0);
    chk("rst_rb_wdata", rb_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_flag_z", flag_z, 0);
    reset = 1'b1;
    @(negedge clk);

    //             op      a   b   d   imm    res    c  z  err lat
    tbl[0]  = mk(OP_LDI, 15, 15,  3, 8'h7F, 8'h7F, 0, 0, 0,  3);
    tbl[1]  = mk(OP_LDI,  0,  0,  1, 8'hF0, 8'hF0, 0, 0, 0,  3);
    tbl[2]  = mk(OP_LDI,  0,  0,  2, 8'h20, 8'h20, 0, 0, 0,  3);
    tbl[3]  = mk(OP_ADD,  1,  2,  4, 8'h00, 8'h10, 1, 0, 0,  5);
    tbl[4]  = mk(OP_SUB,  2,  1,  5, 8'h00, 8'h30, 1, 0, 0,  5);
    tbl[5]  = mk(OP_XOR,  4,  4,  4, 8'h00, 8'h00, 0, 1, 0,  5);
    tbl[6]  = mk(OP_AND,  1,  2,  6, 8'h00, 8'h20, 0, 0, 0,  5);
    tbl[7]  = mk(OP_OR,   3,  2,  7, 8'h00, 8'h7F, 0, 0, 0,  5);
    tbl[8]  = mk(OP_MOV,  5, 15,  8, 8'h00, 8'h30, 0, 0, 0,  4);
    tbl[9]  = mk(OP_ADD,  1,  1,  9, 8'h00, 8'hE0, 1, 0, 0,  5);
    tbl[10] = mk(OP_ADD,  1, 12,  6, 8'h00, 8'hE0, 1, 0, 1,  1);
    tbl[11] = mk(OP_MOV, 10,  0,  0, 8'h00, 8'hE0, 1, 0, 1,  1);
    tbl[12] = mk(OP_LDI,  0,  0, 15, 8'h05, 8'hE0, 1, 0, 1,  1);
    tbl[13] = mk(OP_SUB,  3,  1,  0, 8'h00, 8'h8F, 1, 0, 0,  5);
    tbl[14] = mk(OP_LDI,  0,  0,  4, 8'hAA, 8'hAA, 0, 0, 0,  3);
    tbl[15] = mk(OP_CLR, 12, 12, 15, 8'h00, 8'h00, 0, 1, 0, 11);

    for (int i = 0; i < 16; i++) do_cmd(tbl[i]);

    // Reset during RD_B of an ADD must abort with no write to dst.
    do_cmd(mk(OP_LDI, 0, 0, 3, 8'hAA, 8'hAA, 0, 0, 0, 3));
    do_cmd(mk(OP_LDI, 0, 0, 1, 8'h01, 8'h01, 0, 0, 0, 3));
    do_cmd(mk(OP_LDI, 0, 0, 2, 8'h02, 8'h02, 0, 0, 0, 3));
    wait_ready();
    wlog.delete();
    cmd_op    = OP_ADD;
    cmd_src_a = 4'd1;
    cmd_src_b = 4'd2;
    cmd_dst   = 4'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_rb_address", rb_address, 2);
    reset = 1'b0;
    #1;
    chk("abort_rb_we", rb_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rb_address", rb_address, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_write", wlog.size(), 0);
    chk("abort_dst_kept", bank[3], 8'hAA);
    chk("abort_done_low", done, 0);
    do_cmd(mk(OP_LDI, 0, 0, 3, 8'h3C, 8'h3C, 0, 0, 0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
